// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// default operand widths.
package seq_div_pkg;

  localparam int DIV_DW = 8;
  localparam int DIV_VW = 4;
  localparam int CNT_W  = $clog2(DIV_DW + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   rem,
  input  logic          next_bit,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   rem_next,
  output logic          q_bit
);

  logic [VW:0] rem_shift;
  logic [VW:0] divisor_ext;

  always_comb begin
    rem_shift   = {rem[VW-1:0], next_bit};
    divisor_ext = {1'b0, divisor};
    if (rem_shift >= divisor_ext) begin
      rem_next = rem_shift - divisor_ext;
      q_bit    = 1'b1;
    end else begin
      rem_next = rem_shift;
      q_bit    = 1'b0;
    end
  end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done
// handshake, fixed DW-cycle latency including the divide-by-zero case.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DW - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic [DW-1:0] dvd_sh;
  logic [DW-1:0] quo_sh;
  logic [VW-1:0] dvs;
  logic [VW-1:0] dvd_low;
  logic [VW:0]   part_rem;
  logic          zero_div;
  logic [VW:0]   rem_next;
  logic          q_bit;
  logic          accept;
  logic          last_step;

  div_step #(.VW(VW)) u_step (
    .rem      (part_rem),
    .next_bit (dvd_sh[DW-1]),
    .divisor  (dvs),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start)     state_next = ST_CALC;
      ST_CALC: if (last_step) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == ST_CALC);
    accept    = (state == ST_IDLE) && start;
    last_step = (state == ST_CALC) && (count == LAST_COUNT);
  end

  // The low dividend bits are kept separately because the shift register
  // has consumed them by the time a divide-by-zero result is forced.
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      dvd_sh      <= '0;
      quo_sh      <= '0;
      dvs         <= '0;
      dvd_low     <= '0;
      part_rem    <= '0;
      zero_div    <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        dvd_sh   <= dividend;
        dvd_low  <= dividend[VW-1:0];
        dvs      <= divisor;
        zero_div <= (divisor == '0);
        part_rem <= '0;
        quo_sh   <= '0;
        count    <= '0;
      end else if (busy) begin
        dvd_sh   <= {dvd_sh[DW-2:0], 1'b0};
        part_rem <= rem_next;
        quo_sh   <= {quo_sh[DW-2:0], q_bit};
        count    <= count + 1'b1;
        if (last_step) begin
          done        <= 1'b1;
          div_by_zero <= zero_div;
          if (zero_div) begin
            quotient  <= '1;
            remainder <= dvd_low;
          end else begin
            quotient  <= {quo_sh[DW-2:0], q_bit};
            remainder <= rem_next[VW-1:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: table vectors, handshake corner cases and
// an exhaustive sweep against a behavioural divide model.
module tb_seq_div;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;

  typedef struct packed {
    logic [7:0] dd;
    logic [3:0] dv;
    exp_t       exp;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int   errors;
  int   checks;
  exp_t sb[$];
  vec_t vecs[10];

  seq_div dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t ref_div(input logic [7:0] dd, input logic [3:0] dv);
    exp_t e;
    if (dv == 4'd0) begin
      e.q  = 8'hFF;
      e.r  = dd[3:0];
      e.dz = 1'b1;
    end else begin
      e.q  = dd / {4'd0, dv};
      e.r  = 4'(dd % {4'd0, dv});
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic check_val(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_output();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: done with no pending op, got q=%0d r=%0d", quotient, remainder);
    end else begin
      e = sb.pop_front();
      check_val("quotient", quotient, e.q);
      check_val("remainder", remainder, e.r);
      check_val("div_by_zero", div_by_zero, e.dz);
    end
  endtask

  // Drives start for exactly one accepting edge, then scrambles the operands.
  task automatic start_op(input logic [7:0] dd, input logic [3:0] dv, input exp_t e);
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
  endtask

  task automatic wait_result(input int already);
    int lat;
    bit seen;
    bit busy_ok;
    lat     = 0;
    seen    = 0;
    busy_ok = 1;
    for (int k = already + 1; k <= already + 20 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1;
        lat  = k;
      end else if (!busy) begin
        busy_ok = 0;
      end
    end
    check_val("done_latency", lat, 8);
    check_val("busy_held", busy_ok, 1);
    if (seen) begin
      check_val("busy_at_done", busy, 0);
      check_output();
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] dd, input logic [3:0] dv, input exp_t e);
    @(negedge clk);
    start_op(dd, dv, e);
    wait_result(0);
    @(posedge clk);
    #1;
    check_val("done_pulse_width", done, 0);
  endtask

  initial begin
    int extra;
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    vecs[0] = '{8'd100, 4'd10, '{8'd10,  4'd0, 1'b0}};
    vecs[1] = '{8'd84,  4'd14, '{8'd6,   4'd0, 1'b0}};
    vecs[2] = '{8'd108, 4'd12, '{8'd9,   4'd0, 1'b0}};
    vecs[3] = '{8'd10,  4'd1,  '{8'd10,  4'd0, 1'b0}};
    vecs[4] = '{8'd255, 4'd7,  '{8'd36,  4'd3, 1'b0}};
    vecs[5] = '{8'd0,   4'd5,  '{8'd0,   4'd0, 1'b0}};
    vecs[6] = '{8'd5,   4'd9,  '{8'd0,   4'd5, 1'b0}};
    vecs[7] = '{8'd255, 4'd15, '{8'd17,  4'd0, 1'b0}};
    vecs[8] = '{8'hA6,  4'd0,  '{8'hFF,  4'h6, 1'b1}};
    vecs[9] = '{8'd20,  4'd3,  '{8'd6,   4'd2, 1'b0}};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("reset_busy", busy, 0);
    check_val("reset_done", done, 0);
    check_val("reset_quotient", quotient, 0);
    check_val("reset_remainder", remainder, 0);
    check_val("reset_dbz", div_by_zero, 0);

    $display("[TB] directed table vectors");
    foreach (vecs[i]) apply_stimulus(vecs[i].dd, vecs[i].dv, vecs[i].exp);

    $display("[TB] start while busy is ignored");
    @(negedge clk);
    start_op(8'd50, 4'd5, '{8'd10, 4'd0, 1'b0});
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    start    = 1'b1;
    dividend = 8'd99;
    divisor  = 4'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_result(3);
    extra = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check_val("no_extra_done", extra, 0);
    check_val("idle_after_ignored", busy, 0);

    $display("[TB] reset during calculation");
    @(negedge clk);
    start_op(8'd200, 4'd3, '{8'd66, 4'd2, 1'b0});
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("abort_busy", busy, 0);
    check_val("abort_done", done, 0);
    check_val("abort_quotient", quotient, 0);
    check_val("abort_remainder", remainder, 0);
    check_val("abort_dbz", div_by_zero, 0);
    sb.delete();
    rst   = 1'b0;
    extra = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check_val("abort_no_done", extra, 0);
    apply_stimulus(8'd200, 4'd3, '{8'd66, 4'd2, 1'b0});

    $display("[TB] back-to-back start in done cycle");
    @(negedge clk);
    start_op(8'd10, 4'd1, '{8'd10, 4'd0, 1'b0});
    wait_result(0);
    start_op(8'd77, 4'd4, '{8'd19, 4'd1, 1'b0});
    check_val("b2b_done_pulse_width", done, 0);
    check_val("b2b_accepted", busy, 1);
    wait_result(0);
    @(posedge clk);
    #1;
    check_val("done_pulse_width", done, 0);

    $display("[TB] exhaustive sweep");
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        apply_stimulus(8'(a), 4'(b), ref_div(8'(a), 4'(b)));
      end
    end

    check_val("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
